// File: rtl/soc_system_smoker_with_paper_cpu_debug_ocimem.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : soc_system_smoker_with_paper_cpu_debug_ocimem                 |
// | Purpose  : Debug-monitor memory controller for the smoker_with_paper     |
// |            Nios II core. Decodes JTAG debug-slave strobes and the jdo    |
// |            word into accesses on a single-port debug RAM, returns        |
// |            MonDReg / monitor flags, and shares the RAM with a CPU-side   |
// |            Avalon-MM slave (JTAG has priority).                          |
// | Ports    : clk, reset            - system clock, sync active-high reset  |
// |            jdo, take_*_ocimem_*  - JTAG command word and strobes         |
// |            avs_*                 - CPU Avalon-MM slave (MSB of address   |
// |                                    selects the status register)          |
// |            ram_*                 - single-port RAM, 1-cycle read latency |
// |            MonDReg               - last JTAG read data                   |
// |            monitor_ready/_error  - sticky monitor flags                  |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module soc_system_smoker_with_paper_cpu_debug_ocimem #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic [ADDR_W:0]   avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  output logic [31:0]       avs_readdata,
  output logic              avs_waitrequest,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  output logic              ram_we,
  output logic              ram_re,
  input  logic [31:0]       ram_rdata,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    JWR  = 3'd1,
    JRD  = 3'd2,
    JCAP = 3'd3,
    CRD  = 3'd4,
    CCAP = 3'd5
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0] jaddr;
  logic              autoinc;
  logic              pend_valid;
  logic              pend_wr;
  logic [31:0]       pend_data;

  // JTAG request decode. Only reads and writes occupy the queue; a bare
  // address load (jdo[34]=0) needs no RAM access.
  logic jtag_rd_req, jtag_wr_req, jtag_req, any_strobe;
  logic draining, queue_full, accept, drop, addr_load, flag_clr;

  assign jtag_rd_req = take_no_action_ocimem_a | (take_action_ocimem_a & jdo[34]);
  assign jtag_wr_req = take_action_ocimem_b;
  assign jtag_req    = jtag_rd_req | jtag_wr_req;
  assign any_strobe  = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;

  // The single queue entry empties at the end of JWR/JRD, so a strobe in that
  // same cycle can take its place.
  assign draining   = (state == JWR) || (state == JRD);
  assign queue_full = pend_valid & ~draining;
  assign accept     = jtag_req & ~queue_full;
  assign drop       = jtag_req & queue_full;
  // A dropped read command is discarded entirely, including its address load.
  assign addr_load  = take_action_ocimem_a & ~drop;
  assign flag_clr   = addr_load & jdo[33];

  // CPU request decode; read+write together is handled as a read.
  logic status_sel, cpu_rd, cpu_wr, jtag_block;
  logic cpu_ram_wr_go, cpu_ram_rd_go, cpu_done;
  logic set_ready, set_error;

  assign status_sel    = avs_address[ADDR_W];
  assign cpu_rd        = avs_read;
  assign cpu_wr        = avs_write & ~avs_read;
  assign jtag_block    = any_strobe | pend_valid;
  assign cpu_ram_wr_go = cpu_wr & ~status_sel & (state == IDLE) & ~jtag_block;
  assign cpu_ram_rd_go = cpu_rd & ~status_sel & (state == IDLE) & ~jtag_block;
  assign cpu_done      = status_sel | cpu_ram_wr_go | (cpu_rd & ~status_sel & (state == CCAP));

  assign set_ready = cpu_wr & status_sel & avs_writedata[0];
  assign set_error = (cpu_wr & status_sel & avs_writedata[1]) | drop;

  // Bits of jdo that carry nothing for this block.
  logic unused_jdo_bits;
  assign unused_jdo_bits = ^{jdo[37:36], jdo[2:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    ram_we          = 1'b0;
    ram_re          = 1'b0;
    ram_addr        = avs_address[ADDR_W-1:0];
    ram_wdata       = avs_writedata;
    avs_readdata    = 32'h0;
    avs_waitrequest = (avs_read | avs_write) & ~cpu_done;

    case (state)
      IDLE: begin
        if (pend_valid) begin
          state_nxt = pend_wr ? JWR : JRD;
        end else if (accept) begin
          // Empty queue: start the JTAG access on the very next cycle.
          state_nxt = jtag_wr_req ? JWR : JRD;
        end else if (cpu_ram_rd_go) begin
          state_nxt = CRD;
        end
        ram_we = cpu_ram_wr_go;
      end
      JWR: begin
        ram_we    = 1'b1;
        ram_addr  = jaddr;
        ram_wdata = pend_data;
        state_nxt = IDLE;
      end
      JRD: begin
        ram_re    = 1'b1;
        ram_addr  = jaddr;
        state_nxt = JCAP;
      end
      JCAP: state_nxt = IDLE;
      CRD: begin
        ram_re    = 1'b1;
        state_nxt = CCAP;
      end
      CCAP: begin
        avs_readdata = ram_rdata;
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    if (cpu_rd & status_sel) begin
      avs_readdata = {30'b0, monitor_error, monitor_ready};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      jaddr         <= '0;
      autoinc       <= 1'b0;
      pend_valid    <= 1'b0;
      pend_wr       <= 1'b0;
      pend_data     <= 32'h0;
      MonDReg       <= 32'h0;
      monitor_ready <= 1'b0;
      monitor_error <= 1'b0;
    end else begin
      if (accept) begin
        pend_valid <= 1'b1;
        pend_wr    <= jtag_wr_req;
        pend_data  <= jdo[34:3];
      end else if (draining) begin
        pend_valid <= 1'b0;
      end

      // A fresh address load overrides the post-access increment.
      if (addr_load) begin
        jaddr   <= jdo[17 +: ADDR_W];
        autoinc <= jdo[35];
      end else if (draining && autoinc) begin
        jaddr <= jaddr + ADDR_W'(1);
      end

      if (state == JCAP) begin
        MonDReg <= ram_rdata;
      end

      // CPU set takes precedence over a simultaneous JTAG clear.
      monitor_ready <= (monitor_ready & ~flag_clr) | set_ready;
      monitor_error <= (monitor_error & ~flag_clr) | set_error;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_soc_system_smoker_with_paper_cpu_debug_ocimem.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_soc_system_smoker_with_paper_cpu_debug_ocimem              |
// | Purpose  : Self-checking bench: directed JTAG/CPU sequences, a table of  |
// |            single-cycle CPU accesses and a randomized transaction mix    |
// |            against a memory/flag reference model.                       |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_soc_system_smoker_with_paper_cpu_debug_ocimem;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam logic [ADDR_W:0] STATUS_ADDR = {1'b1, {ADDR_W{1'b0}}};

  logic              clk = 1'b0;
  logic              reset;
  logic [37:0]       jdo;
  logic              ta_a, ta_b, tna_a;
  logic [ADDR_W:0]   avs_address;
  logic              avs_read, avs_write;
  logic [31:0]       avs_writedata, avs_readdata;
  logic              avs_waitrequest;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata, ram_rdata;
  logic              ram_we, ram_re;
  logic [31:0]       mon_dreg;
  logic              monitor_ready, monitor_error;

  soc_system_smoker_with_paper_cpu_debug_ocimem #(.ADDR_W(ADDR_W)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .jdo                     (jdo),
    .take_action_ocimem_a    (ta_a),
    .take_action_ocimem_b    (ta_b),
    .take_no_action_ocimem_a (tna_a),
    .avs_address             (avs_address),
    .avs_read                (avs_read),
    .avs_write               (avs_write),
    .avs_writedata           (avs_writedata),
    .avs_readdata            (avs_readdata),
    .avs_waitrequest         (avs_waitrequest),
    .ram_addr                (ram_addr),
    .ram_wdata               (ram_wdata),
    .ram_we                  (ram_we),
    .ram_re                  (ram_re),
    .ram_rdata               (ram_rdata),
    .MonDReg                 (mon_dreg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error)
  );

  always #5 clk = ~clk;

  // Debug RAM: synchronous write, read data one cycle after ram_re.
  logic [31:0] ram [DEPTH];
  always @(posedge clk) begin
    if (ram_we) ram[ram_addr] <= ram_wdata;
    if (ram_re) ram_rdata <= ram[ram_addr];
  end

  // Reference model: memory contents plus the JTAG pointer and flags.
  logic [31:0] m_mem [DEPTH];
  int          m_jaddr;
  bit          m_autoinc, m_rdy, m_err;
  logic [31:0] m_mond;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [ADDR_W:0] addr;
    logic            rd;
    logic            wr;
    logic [31:0]     wdata;
    logic            exp_wait;
    logic [31:0]     exp_rdata;
    logic            exp_we;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [37:0] make_a(input logic [ADDR_W-1:0] a, input bit ai, input bit clr, input bit rd);
    logic [37:0] j;
    j = '0;
    j[17 +: ADDR_W] = a;
    j[35] = ai;
    j[33] = clr;
    j[34] = rd;
    return j;
  endfunction

  function automatic logic [37:0] make_b(input logic [31:0] d);
    logic [37:0] j;
    j = '0;
    j[34:3] = d;
    return j;
  endfunction

  function automatic logic [31:0] pattern(input int i);
    logic [7:0] b;
    b = 8'(i);
    return {b, ~b, 8'h5A, b};
  endfunction

  task automatic model_access(input bit wr, input logic [31:0] d);
    if (wr) m_mem[m_jaddr] = d;
    else    m_mond = m_mem[m_jaddr];
    if (m_autoinc) m_jaddr = (m_jaddr + 1) % DEPTH;
  endtask

  task automatic model_cpu_write(input logic [ADDR_W:0] a, input logic [31:0] d);
    if (a[ADDR_W]) begin
      m_rdy = m_rdy | d[0];
      m_err = m_err | d[1];
    end else begin
      m_mem[a[ADDR_W-1:0]] = d;
    end
  endtask

  // Serial JTAG operations: strobe for one cycle, then let the FSM settle.
  task automatic jtag_set(input int a, input bit ai, input bit clr, input bit rd);
    jdo = make_a(ADDR_W'(a), ai, clr, rd);
    ta_a = 1'b1;
    cycle();
    ta_a = 1'b0;
    jdo = '0;
    repeat (3) cycle();
    m_jaddr = a;
    m_autoinc = ai;
    if (clr) begin m_rdy = 0; m_err = 0; end
    if (rd) model_access(1'b0, 32'h0);
  endtask

  task automatic jtag_write(input logic [31:0] d);
    jdo = make_b(d);
    ta_b = 1'b1;
    cycle();
    ta_b = 1'b0;
    jdo = '0;
    repeat (3) cycle();
    model_access(1'b1, d);
  endtask

  task automatic jtag_read();
    tna_a = 1'b1;
    cycle();
    tna_a = 1'b0;
    repeat (3) cycle();
    model_access(1'b0, 32'h0);
  endtask

  task automatic cpu_write(input logic [ADDR_W:0] a, input logic [31:0] d, output int waits);
    bit done;
    done = 0;
    waits = 0;
    avs_address = a;
    avs_writedata = d;
    avs_write = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (!avs_waitrequest) done = 1;
      else begin
        waits++;
        if (waits >= 40) done = 1;
      end
      cycle();
    end
    avs_write = 1'b0;
    model_cpu_write(a, d);
  endtask

  task automatic cpu_read(input logic [ADDR_W:0] a, output logic [31:0] data, output int waits);
    bit done;
    done = 0;
    waits = 0;
    data = '0;
    avs_address = a;
    avs_read = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (!avs_waitrequest) begin
        done = 1;
        data = avs_readdata;
      end else begin
        waits++;
        if (waits >= 40) done = 1;
      end
      cycle();
    end
    avs_read = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion, expected summary before time limit");
    $fatal(1);
  end

  initial begin
    vec_t        tbl [10];
    logic [31:0] rdat;
    logic [31:0] d [3];
    int          w, we_cnt, re_cnt;
    bit          done;

    reset = 1'b1;
    jdo = '0; ta_a = 0; ta_b = 0; tna_a = 0;
    avs_address = '0; avs_read = 0; avs_write = 0; avs_writedata = '0;
    m_jaddr = 0; m_autoinc = 0; m_rdy = 0; m_err = 0; m_mond = 0;

    // ---------------- reset state ----------------
    repeat (3) cycle();
    reset = 1'b0;
    @(negedge clk);
    check("reset_mondreg", mon_dreg, 32'h0);
    check("reset_ready", 32'(monitor_ready), 32'h0);
    check("reset_error", 32'(monitor_error), 32'h0);
    check("reset_ram_we", 32'(ram_we), 32'h0);
    check("reset_ram_re", 32'(ram_re), 32'h0);
    check("reset_waitreq", 32'(avs_waitrequest), 32'h0);
    check("reset_readdata", avs_readdata, 32'h0);
    cycle();

    // Load the RAM through the CPU port; every RAM write is zero-wait.
    for (int i = 0; i < DEPTH; i++) begin
      cpu_write((ADDR_W+1)'(i), pattern(i), w);
      check("init_write_waits", 32'(w), 32'h0);
    end

    // ---------------- single-cycle CPU access table ----------------
    tbl[0] = '{STATUS_ADDR, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0, 1'b0};
    tbl[1] = '{STATUS_ADDR, 1'b0, 1'b1, 32'h0,        1'b0, 32'h0, 1'b0};
    tbl[2] = '{STATUS_ADDR, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0, 1'b0};
    tbl[3] = '{STATUS_ADDR, 1'b0, 1'b1, 32'h1,        1'b0, 32'h0, 1'b0};
    tbl[4] = '{STATUS_ADDR, 1'b1, 1'b0, 32'h0,        1'b0, 32'h1, 1'b0};
    tbl[5] = '{9'd7,        1'b0, 1'b1, 32'h0BADF00D, 1'b0, 32'h0, 1'b1};
    tbl[6] = '{STATUS_ADDR, 1'b0, 1'b1, 32'h2,        1'b0, 32'h0, 1'b0};
    tbl[7] = '{STATUS_ADDR, 1'b1, 1'b0, 32'h0,        1'b0, 32'h3, 1'b0};
    tbl[8] = '{9'd200,      1'b0, 1'b1, 32'hCAFE0200, 1'b0, 32'h0, 1'b1};
    tbl[9] = '{9'd0,        1'b0, 1'b0, 32'h0,        1'b0, 32'h0, 1'b0};
    for (int i = 0; i < 10; i++) begin
      avs_address = tbl[i].addr;
      avs_read = tbl[i].rd;
      avs_write = tbl[i].wr;
      avs_writedata = tbl[i].wdata;
      @(negedge clk);
      check($sformatf("tbl%0d_waitreq", i), 32'(avs_waitrequest), 32'(tbl[i].exp_wait));
      check($sformatf("tbl%0d_ram_we", i), 32'(ram_we), 32'(tbl[i].exp_we));
      if (tbl[i].rd) check($sformatf("tbl%0d_readdata", i), avs_readdata, tbl[i].exp_rdata);
      cycle();
      if (tbl[i].wr && !tbl[i].rd) model_cpu_write(tbl[i].addr, tbl[i].wdata);
    end
    avs_read = 0; avs_write = 0; avs_writedata = '0;

    cpu_read(9'd7, rdat, w);
    check("cpu_read7_data", rdat, 32'h0BADF00D);
    check("cpu_read7_waits", 32'(w), 32'd2);

    // JTAG clear of both flags.
    jtag_set(0, 0, 1, 0);
    cpu_read(STATUS_ADDR, rdat, w);
    check("status_after_clear", rdat, 32'h0);
    check("status_read_waits", 32'(w), 32'h0);

    // ---------------- JTAG read latency ----------------
    cpu_write(9'd5, 32'hDEADBEEF, w);
    cpu_write(9'd6, 32'h66666666, w);
    jdo = make_a(8'd5, 1'b0, 1'b0, 1'b1);
    ta_a = 1'b1;
    cycle();
    ta_a = 1'b0;
    jdo = '0;
    @(negedge clk);
    check("jrd_ram_re_n1", 32'(ram_re), 32'h1);
    check("jrd_ram_addr_n1", 32'(ram_addr), 32'd5);
    cycle();
    @(negedge clk);
    check("jrd_mondreg_n2_old", mon_dreg, 32'h0);
    cycle();
    @(negedge clk);
    check("jrd_mondreg_n3", mon_dreg, 32'hDEADBEEF);
    cycle();
    m_jaddr = 5; m_autoinc = 0;
    model_access(1'b0, 32'h0);
    jtag_read();
    check("jrd_no_autoinc", mon_dreg, 32'hDEADBEEF);

    // ---------------- auto-increment wrap ----------------
    jtag_set(255, 1, 0, 0);
    jtag_write(32'h11);
    jtag_write(32'h22);
    check("wrap_ram255", ram[255], 32'h11);
    check("wrap_ram0", ram[0], 32'h22);
    jtag_read();
    check("wrap_jaddr_is_1", mon_dreg, pattern(1));

    // ---------------- JTAG/CPU contention ----------------
    jtag_set(9, 0, 0, 0);
    avs_address = 9'd3;
    avs_read = 1'b1;
    tna_a = 1'b1;
    w = 0;
    done = 0;
    rdat = '0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (c == 1) begin
        check("contend_jtag_first_re", 32'(ram_re), 32'h1);
        check("contend_jtag_first_addr", 32'(ram_addr), 32'd9);
      end
      if (!avs_waitrequest) begin
        done = 1;
        rdat = avs_readdata;
      end else begin
        w++;
      end
      cycle();
      tna_a = 1'b0;
    end
    avs_read = 1'b0;
    model_access(1'b0, 32'h0);
    check("contend_cpu_data", rdat, m_mem[3]);
    check("contend_cpu_waits", 32'(w), 32'd5);
    check("contend_mondreg", mon_dreg, m_mond);

    // ---------------- queue overflow ----------------
    jtag_set(20, 0, 1, 0);
    d[0] = 32'hA1A1A1A1; d[1] = 32'hB2B2B2B2; d[2] = 32'hC3C3C3C3;
    we_cnt = 0;
    re_cnt = 0;
    for (int i = 0; i < 9; i++) begin
      ta_b = (i < 3);
      jdo = (i < 3) ? make_b(d[i]) : '0;
      @(negedge clk);
      if (ram_we) we_cnt++;
      if (ram_re) re_cnt++;
      cycle();
    end
    ta_b = 1'b0;
    jdo = '0;
    m_mem[20] = d[1];
    m_err = 1;
    check("ovf_write_count", 32'(we_cnt), 32'd2);
    check("ovf_read_count", 32'(re_cnt), 32'd0);
    check("ovf_ram20", ram[20], d[1]);
    check("ovf_error_flag", 32'(monitor_error), 32'h1);

    // ---------------- same-cycle CPU set and JTAG clear ----------------
    jdo = make_a(8'd20, 1'b0, 1'b1, 1'b0);
    ta_a = 1'b1;
    avs_address = STATUS_ADDR;
    avs_writedata = 32'h1;
    avs_write = 1'b1;
    @(negedge clk);
    check("setclr_waitreq", 32'(avs_waitrequest), 32'h0);
    cycle();
    ta_a = 1'b0; jdo = '0; avs_write = 1'b0; avs_writedata = '0;
    m_rdy = 1; m_err = 0;
    cpu_read(STATUS_ADDR, rdat, w);
    check("setclr_status", rdat, 32'h1);
    check("setclr_ready_port", 32'(monitor_ready), 32'h1);

    // ---------------- reset during JRD ----------------
    jdo = make_a(8'd5, 1'b0, 1'b0, 1'b1);
    ta_a = 1'b1;
    cycle();
    ta_a = 1'b0;
    jdo = '0;
    reset = 1'b1;
    @(negedge clk);
    check("rst_jrd_active", 32'(ram_re), 32'h1);
    cycle();
    reset = 1'b0;
    @(negedge clk);
    check("rst_after_ram_re", 32'(ram_re), 32'h0);
    check("rst_after_ram_we", 32'(ram_we), 32'h0);
    check("rst_after_mondreg", mon_dreg, 32'h0);
    check("rst_after_ready", 32'(monitor_ready), 32'h0);
    cycle();
    m_jaddr = 0; m_autoinc = 0; m_rdy = 0; m_err = 0; m_mond = 0;
    cpu_write(9'd30, 32'h30303030, w);
    check("rst_cpu_write_waits", 32'(w), 32'h0);
    check("rst_cpu_write_ram", ram[30], 32'h30303030);

    // ---------------- randomized transactions ----------------
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 6))
        0: begin
          jtag_set($urandom_range(0, DEPTH-1), 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
          check("rnd_set_mondreg", mon_dreg, m_mond);
        end
        1: begin
          jtag_write($urandom);
          check("rnd_jwr_mondreg", mon_dreg, m_mond);
        end
        2: begin
          jtag_read();
          check("rnd_jrd_mondreg", mon_dreg, m_mond);
        end
        3: begin
          cpu_write((ADDR_W+1)'($urandom_range(0, DEPTH-1)), $urandom, w);
          check("rnd_cwr_waits", 32'(w), 32'h0);
        end
        4: begin
          logic [ADDR_W:0] a;
          a = (ADDR_W+1)'($urandom_range(0, DEPTH-1));
          cpu_read(a, rdat, w);
          check("rnd_crd_data", rdat, m_mem[a[ADDR_W-1:0]]);
          check("rnd_crd_waits", 32'(w), 32'd2);
        end
        5: begin
          cpu_write(STATUS_ADDR, 32'($urandom_range(0, 3)), w);
          check("rnd_swr_waits", 32'(w), 32'h0);
        end
        default: begin
          cpu_read(STATUS_ADDR, rdat, w);
          check("rnd_status", rdat, {30'b0, m_err, m_rdy});
          check("rnd_status_waits", 32'(w), 32'h0);
        end
      endcase
    end

    // ---------------- final contents ----------------
    for (int i = 0; i < DEPTH; i++) begin
      check($sformatf("final_ram[%0d]", i), ram[i], m_mem[i]);
    end
    check("final_ready", 32'(monitor_ready), 32'(m_rdy));
    check("final_error", 32'(monitor_error), 32'(m_err));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
